udp_tx_fifo_ctrl: RTL

Single-clock first-word-fall-through (FWFT) FIFO controller for the UDP transmit path.
- Owns the write/read pointers and the occupancy logic, plus one output holding register.
- Storage is a distributed simple-dual-port RAM with an unregistered (asynchronous) read port.
- The packet assembler pushes payload words on the write side. The MAC framer drains them on the read side, where the head word is always presented on rd_data.

---
 rtl/udp_fifo_pkg.sv | 17 +
 rtl/udp_fifo_ptr.sv | 35 +++
 rtl/udp_tx_fifo_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/udp_fifo_pkg.sv
// rtl/udp_fifo_pkg.sv - shared widths and threshold defaults for the UDP tx FIFO
package udp_fifo_pkg;

  localparam int UDP_TX_DATA_WIDTH    = 8;
  localparam int UDP_TX_ADDR_WIDTH    = 4;
  localparam int UDP_AE_LEVEL_DEFAULT = 2;

  // One extra pointer bit acts as the wrap flag for full/empty disambiguation
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int af_level_default(input int addr_width);
    return (2 ** addr_width) - 2;
  endfunction

endpackage

// File: rtl/udp_fifo_ptr.sv
// rtl/udp_fifo_ptr.sv - wrap-flagged FIFO pointer with full (write side) or empty (read side) compare
module udp_fifo_ptr
  import udp_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = UDP_TX_ADDR_WIDTH,
  parameter bit IS_WR      = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             inc_i,
  input  logic [ptr_width(ADDR_WIDTH)-1:0] other_ptr_i,
  output logic [ptr_width(ADDR_WIDTH)-1:0] ptr_o,
  output logic                             flag_o
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          same_addr, same_wrap;

  always_comb begin
    ptr_d = ptr_q + PW'(inc_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign same_addr = (ptr_q[ADDR_WIDTH-1:0] == other_ptr_i[ADDR_WIDTH-1:0]);
  assign same_wrap = (ptr_q[PW-1] == other_ptr_i[PW-1]);
  assign ptr_o     = ptr_q;
  assign flag_o    = IS_WR ? (same_addr & ~same_wrap) : (same_addr & same_wrap);

endmodule

// File: rtl/udp_tx_fifo_ctrl.sv
// rtl/udp_tx_fifo_ctrl.sv - FWFT FIFO controller: async-read RAM plus one output holding register
module udp_tx_fifo_ctrl
  import udp_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = UDP_TX_ADDR_WIDTH,
  parameter int DATA_WIDTH = UDP_TX_DATA_WIDTH,
  parameter int AF_LEVEL   = af_level_default(ADDR_WIDTH),
  parameter int AE_LEVEL   = UDP_AE_LEVEL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int            PW    = ptr_width(ADDR_WIDTH);
  localparam int            DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AF_L  = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L  = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  ram_full, ram_empty;
  logic                  push, pop, load;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  ovf_q, unf_q;

  udp_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .IS_WR(1'b1)) u_wr_ptr (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (push),
    .other_ptr_i (rd_ptr),
    .ptr_o       (wr_ptr),
    .flag_o      (ram_full)
  );

  udp_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .IS_WR(1'b0)) u_rd_ptr (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (load),
    .other_ptr_i (wr_ptr),
    .ptr_o       (rd_ptr),
    .flag_o      (ram_empty)
  );

  // Load decision uses the pre-edge RAM state, so a word written this edge is never loaded this edge
  always_comb begin
    push      = wr_en & ~ram_full;
    pop       = rd_en & valid_q;
    load      = (~valid_q | pop) & ~ram_empty;
    valid_d   = valid_q;
    rd_data_d = rd_data_q;
    if (load) begin
      valid_d   = 1'b1;
      rd_data_d = mem_q[rd_ptr[ADDR_WIDTH-1:0]];
    end else if (pop) begin
      valid_d   = 1'b0;
    end
    count_d   = count_q + PW'(push) - PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_data_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
      count_q   <= count_d;
      ovf_q     <= wr_en & ram_full;
      unf_q     <= rd_en & ~valid_q;
    end
  end

  assign full         = ram_full;
  assign empty        = ~valid_q;
  assign rd_data      = rd_data_q;
  assign data_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign almost_full  = (count_q >= AF_L);
  assign almost_empty = (count_q <= AE_L);

endmodule
